// File: rtl/regfile_pkg.sv
// Shared register-file write-port types and constants.
// No logic; constants only.
// No flow control of its own.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a force-port-1 override.
// Grant is combinational; last_grant updates at the edge.
// Both grants are held low while reset is high.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       force_mem,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req == 2'b01) begin
        grant = 2'b01;
      end else if (req == 2'b10) begin
        grant = 2'b10;
      end else if (req == 2'b11) begin
        // The port that did not win last time takes a contested cycle.
        if (force_mem || (last_grant == PORT_ALU)) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_MEM;
    end else if (|grant) begin
      last_grant <= grant[1] ? PORT_MEM : PORT_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (port 0) and memory (port 1) writeback.
// One cycle from acceptance to enc/addrc/datac; ready is combinational, one grant per cycle.
// Optional REGWR_CONFLICT_CNT_EN adds a saturating count of both-valid cycles.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 enc,
  output logic [ADDR_W-1:0]    addrc,
  output logic [DATA_W-1:0]    datac,
`ifdef REGWR_CONFLICT_CNT_EN
  output logic [15:0]          conflict_cnt,
`endif
  output logic [2**ADDR_W-1:0] pending
);

  logic [1:0]        grant;
  logic              same_addr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // The memory result belongs to the older instruction, so it must land first.
  assign same_addr = req0_valid && req1_valid && (req0_addr == req1_addr);

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       ({req1_valid, req0_valid}),
    .force_mem (same_addr),
    .grant     (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      enc   <= 1'b0;
      addrc <= '0;
      datac <= '0;
    end else if (|grant) begin
      addrc <= sel_addr;
      datac <= sel_data;
      enc   <= !(DROP_R0 && (sel_addr == '0));
    end else begin
      enc <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    if (!reset) begin
      if (req0_valid && !req0_ready) pending[req0_addr] = 1'b1;
      if (req1_valid && !req1_ready) pending[req1_addr] = 1'b1;
      if (enc)                       pending[addrc]     = 1'b1;
      if (DROP_R0)                   pending[0]         = 1'b0;
    end
  end

`ifdef REGWR_CONFLICT_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed cases plus randomized traffic against a reference model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        enc;
  logic [4:0]  addrc;
  logic [31:0] datac;
  logic [31:0] pending;
`ifdef REGWR_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .enc          (enc),
    .addrc        (addrc),
    .datac        (datac),
`ifdef REGWR_CONFLICT_CNT_EN
    .conflict_cnt (conflict_cnt),
`endif
    .pending      (pending)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          check_en  = 1'b0;
  bit          turn      = 1'b0;   // port that wins the next different-address conflict
  bit          prev_reset = 1'b1;
  int          prev_grant = -1;
  bit          prev_both  = 1'b0;
  wr_req_t     prev_req;
  bit          exp_enc;
  logic [4:0]  exp_addrc;
  logic [31:0] exp_datac;
  logic [15:0] exp_cnt;
  bit          exp_rdy0, exp_rdy1;
  logic [31:0] exp_pend;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wr_req_t mk(input logic v, input logic [4:0] a, input logic [31:0] d);
    wr_req_t r;
    r.valid = v;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  // Register file as seen by the write port: a write lands when enc is high at an edge outside reset.
  always @(posedge clock) begin
    if (enc === 1'b1 && reset === 1'b0) d_rf[addrc] <= datac;
  end

  task automatic step(input bit r, input wr_req_t a, input wr_req_t b);
    int g;
    @(posedge clock);
    #1;
    if (exp_enc && !prev_reset) m_rf[exp_addrc] = exp_datac;
    if (prev_reset) begin
      exp_enc   = 1'b0;
      exp_addrc = '0;
      exp_datac = '0;
      exp_cnt   = '0;
      turn      = 1'b0;
    end else begin
      if (prev_grant >= 0) begin
        exp_addrc = prev_req.addr;
        exp_datac = prev_req.data;
        exp_enc   = (prev_req.addr != 5'd0);
        turn      = (prev_grant == 0);
      end else begin
        exp_enc = 1'b0;
      end
      if (prev_both && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    reset      = r;
    req0_valid = a.valid; req0_addr = a.addr; req0_data = a.data;
    req1_valid = b.valid; req1_addr = b.addr; req1_data = b.data;
    g = -1;
    if (!r) begin
      if (a.valid && b.valid) g = (a.addr == b.addr) ? 1 : int'(turn);
      else if (a.valid)       g = 0;
      else if (b.valid)       g = 1;
    end
    exp_rdy0 = (g == 0);
    exp_rdy1 = (g == 1);
    exp_pend = '0;
    if (!r) begin
      if (a.valid && g != 0) exp_pend[a.addr] = 1'b1;
      if (b.valid && g != 1) exp_pend[b.addr] = 1'b1;
      if (exp_enc)           exp_pend[exp_addrc] = 1'b1;
      exp_pend[0] = 1'b0;
    end
    prev_reset = r;
    prev_grant = g;
    prev_req   = (g == 1) ? b : a;
    prev_both  = !r && a.valid && b.valid;
    check_en   = 1'b1;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      check("req0_ready", req0_ready, exp_rdy0);
      check("req1_ready", req1_ready, exp_rdy1);
      check("pending", pending, exp_pend);
      check("enc", enc, exp_enc);
      check("addrc", addrc, exp_addrc);
      check("datac", datac, exp_datac);
`ifdef REGWR_CONFLICT_CNT_EN
      check("conflict_cnt", conflict_cnt, exp_cnt);
`endif
    end
  end

  task automatic pin();
    @(negedge clock);
    #1;
  endtask

  wr_req_t idle, ha, hb;

  initial begin
    idle = '0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // Reset then idle
    step(1'b1, idle, idle);
    pin();
    check("rst_enc", enc, 0);
    check("rst_addrc", addrc, 0);
    check("rst_datac", datac, 0);
    check("rst_pending", pending, 0);
    check("rst_ready0", req0_ready, 0);
    step(1'b1, idle, idle);
    step(1'b0, idle, idle);
    pin();
    check("idle_enc", enc, 0);
    check("idle_pending", pending, 0);

    // Single ALU write
    step(1'b0, mk(1, 5'd5, 32'hDEADBEEF), idle);
    pin();
    check("alu_ready", req0_ready, 1);
    check("alu_pend5_acc", pending[5], 0);
    step(1'b0, idle, idle);
    pin();
    check("alu_enc", enc, 1);
    check("alu_addrc", addrc, 5);
    check("alu_datac", datac, 32'hDEADBEEF);
    check("alu_pend5", pending[5], 1);
    step(1'b0, idle, idle);
    pin();
    check("alu_enc_off", enc, 0);

    // Conflict, different addresses, starting from reset state
    step(1'b1, idle, idle);
    step(1'b0, mk(1, 5'd3, 32'h33), mk(1, 5'd7, 32'h77));
    pin();
    check("diff_ready0", req0_ready, 1);
    check("diff_ready1", req1_ready, 0);
    check("diff_pend7", pending[7], 1);
    step(1'b0, idle, mk(1, 5'd7, 32'h77));
    pin();
    check("diff_ready1_2nd", req1_ready, 1);
    check("diff_addrc_a", addrc, 3);
    step(1'b0, idle, idle);
    pin();
    check("diff_enc_b", enc, 1);
    check("diff_addrc_b", addrc, 7);

    // Same-address conflict: memory first, ALU last
    step(1'b0, mk(1, 5'd9, 32'd1), mk(1, 5'd9, 32'd2));
    pin();
    check("same_ready1", req1_ready, 1);
    check("same_ready0", req0_ready, 0);
    step(1'b0, mk(1, 5'd9, 32'd1), idle);
    pin();
    check("same_ready0_2nd", req0_ready, 1);
    check("same_datac_a", datac, 2);
    step(1'b0, idle, idle);
    pin();
    check("same_datac_b", datac, 1);
    step(1'b0, idle, idle);
    pin();
    check("same_rf9", d_rf[9], 1);

    // Register 0 drop
    step(1'b0, idle, mk(1, 5'd0, 32'hAB));
    pin();
    check("r0_ready1", req1_ready, 1);
    check("r0_pend0", pending[0], 0);
    step(1'b0, idle, idle);
    pin();
    check("r0_enc", enc, 0);
    check("r0_pend0_after", pending[0], 0);

    // Reset the cycle after a grant
    step(1'b0, mk(1, 5'd12, 32'h55), idle);
    step(1'b1, idle, idle);
    pin();
    check("mid_rst_pending", pending, 0);
    step(1'b0, idle, idle);
    pin();
    check("mid_rst_enc", enc, 0);
    check("mid_rst_addrc", addrc, 0);
    step(1'b0, idle, idle);
    pin();
    check("mid_rst_enc_late", enc, 0);

    // Four both-valid cycles after reset
    step(1'b1, idle, idle);
    ha = mk(1, 5'd1, 32'h100);
    hb = mk(1, 5'd2, 32'h200);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, ha, hb);
      if (exp_rdy0) ha = mk(1, 5'(ha.addr + 5'd2), ha.data + 32'd1);
      if (exp_rdy1) hb = mk(1, 5'(hb.addr + 5'd2), hb.data + 32'd1);
    end
    step(1'b0, idle, idle);
`ifdef REGWR_CONFLICT_CNT_EN
    pin();
    check("cnt_four", conflict_cnt, 4);
`endif

    // Randomized traffic
    ha = idle;
    hb = idle;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if (!ha.valid && $urandom_range(0, 9) < 6)
        ha = mk(1, 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)), $urandom);
      if (!hb.valid && $urandom_range(0, 9) < 6)
        hb = mk(1, 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)), $urandom);
      r = ($urandom_range(0, 99) == 0);
      step(r, ha, hb);
      if (exp_rdy0) ha = idle;
      if (exp_rdy1) hb = idle;
    end
    step(1'b0, idle, idle);
    step(1'b0, idle, idle);
    pin();
    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), d_rf[i], m_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
